usb4_logical_layer_lite: RTL and testbench



---
 rtl/usb4_logical_layer_lite.sv | 183 ++++++++++++++++++
 tb/tb_usb4_logical_layer_lite.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb4_logical_layer_lite.sv
// Simplified USB4 logical layer: CLd/TRAINING/CL0 lane init, two-lane byte striping,
// and a small config-space register bank. No scrambler; enable_scr drives an external one.
module usb4_logical_layer_lite #(
  parameter logic [7:0] TS_SYM   = 8'hBC,
  parameter int         TS_COUNT = 16,
  parameter int         SB_DEB   = 4
) (
  input  logic        local_clk,
  input  logic        rst,
  input  logic        lane_disable,
  input  logic        c_read,
  input  logic        c_write,
  input  logic [7:0]  c_address,
  input  logic [31:0] c_data_in,
  output logic [31:0] c_data_out,
  input  logic [15:0] transport_layer_data_in,
  output logic [15:0] transport_layer_data_out,
  input  logic [7:0]  lane_0_rx_i,
  input  logic [7:0]  lane_1_rx_i,
  input  logic        data_incoming,
  input  logic        sbrx,
  output logic        sbtx,
  output logic [7:0]  lane_0_tx_o,
  output logic [7:0]  lane_1_tx_o,
  output logic        enable_scr
);

  typedef enum logic [1:0] {
    CLD      = 2'd0,
    TRAINING = 2'd1,
    CL0      = 2'd2
  } state_e;

  localparam int DEB_W = (SB_DEB   < 2) ? 1 : $clog2(SB_DEB);
  localparam int MW    = (TS_COUNT < 2) ? 1 : $clog2(TS_COUNT);
  localparam logic [31:0] ID_VAL = 32'h0054_4C31;

  state_e            state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [MW-1:0]     match_cnt_q, match_cnt_d;
  logic              scr_en_q, scr_en_d;
  logic [7:0]        lane_0_tx_q, lane_0_tx_d;
  logic [7:0]        lane_1_tx_q, lane_1_tx_d;
  logic [15:0]       rx_data_q, rx_data_d;
  logic [31:0]       c_data_out_q, c_data_out_d;

  logic [5:0]        addr_sel;
  logic              ctrl_wr;
  logic              retrain;
  logic              rx_match;
  logic              link_drop;
  logic [31:0]       match_ext;
  logic [7:0]        match_sat;
  logic [31:0]       rd_data;
  logic              unused_addr_lsbs;

  assign addr_sel         = c_address[7:2];
  assign unused_addr_lsbs = ^c_address[1:0];
  assign ctrl_wr          = c_write && (addr_sel == 6'd1);
  assign retrain          = ctrl_wr && c_data_in[1];
  assign rx_match         = (lane_0_rx_i == TS_SYM) && (lane_1_rx_i == TS_SYM);
  assign link_drop        = lane_disable || !sbrx;

  assign match_ext = 32'(match_cnt_q);
  assign match_sat = (match_ext > 32'd255) ? 8'hFF : match_ext[7:0];

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      CLD: begin
        if (!lane_disable && sbrx) begin
          if (deb_cnt_q == DEB_W'(SB_DEB - 1)) begin
            state_d   = TRAINING;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end else begin
          deb_cnt_d = '0;
        end
      end
      TRAINING: begin
        // Link drop outranks a completing match run in the same cycle.
        if (link_drop) begin
          state_d     = CLD;
          deb_cnt_d   = '0;
          match_cnt_d = '0;
        end else if (data_incoming) begin
          if (!rx_match) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MW'(TS_COUNT - 1)) begin
            state_d     = CL0;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + MW'(1);
          end
        end
      end
      CL0: begin
        if (link_drop) begin
          state_d     = CLD;
          deb_cnt_d   = '0;
          match_cnt_d = '0;
        end else if (retrain) begin
          state_d     = TRAINING;
          match_cnt_d = '0;
        end
      end
      default: begin
        state_d     = CLD;
        deb_cnt_d   = '0;
        match_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    lane_0_tx_d = 8'h00;
    lane_1_tx_d = 8'h00;
    case (state_q)
      TRAINING: begin
        lane_0_tx_d = TS_SYM;
        lane_1_tx_d = TS_SYM;
      end
      CL0: begin
        lane_0_tx_d = transport_layer_data_in[7:0];
        lane_1_tx_d = transport_layer_data_in[15:8];
      end
      default: ;
    endcase

    rx_data_d = rx_data_q;
    if ((state_q == CL0) && data_incoming) begin
      rx_data_d = {lane_1_rx_i, lane_0_rx_i};
    end
  end

  // Reads see pre-write register contents, so a same-cycle write does not leak through.
  always_comb begin
    rd_data = 32'h0;
    case (addr_sel)
      6'd0:    rd_data = {16'h0, match_sat, 6'h0, state_q};
      6'd1:    rd_data = {31'h0, scr_en_q};
      6'd2:    rd_data = ID_VAL;
      default: rd_data = 32'h0;
    endcase

    c_data_out_d = c_read ? rd_data : c_data_out_q;
    scr_en_d     = ctrl_wr ? c_data_in[0] : scr_en_q;
  end

  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CLD;
      deb_cnt_q    <= '0;
      match_cnt_q  <= '0;
      scr_en_q     <= 1'b0;
      lane_0_tx_q  <= 8'h00;
      lane_1_tx_q  <= 8'h00;
      rx_data_q    <= 16'h0;
      c_data_out_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      deb_cnt_q    <= deb_cnt_d;
      match_cnt_q  <= match_cnt_d;
      scr_en_q     <= scr_en_d;
      lane_0_tx_q  <= lane_0_tx_d;
      lane_1_tx_q  <= lane_1_tx_d;
      rx_data_q    <= rx_data_d;
      c_data_out_q <= c_data_out_d;
    end
  end

  assign sbtx                     = (state_q != CLD);
  assign enable_scr               = (state_q == CL0) && scr_en_q;
  assign lane_0_tx_o              = lane_0_tx_q;
  assign lane_1_tx_o              = lane_1_tx_q;
  assign transport_layer_data_out = rx_data_q;
  assign c_data_out               = c_data_out_q;

endmodule

// File: tb/tb_usb4_logical_layer_lite.sv
// Bench for usb4_logical_layer_lite: directed bring-up/config/teardown followed by
// random traffic, all checked against a cycle-level behavioural model of the link.
module tb_usb4_logical_layer_lite;

  localparam logic [7:0]  TS   = 8'hBC;
  localparam int          TSC  = 16;
  localparam int          DEB  = 4;
  localparam logic [31:0] IDV  = 32'h0054_4C31;

  logic        local_clk;
  logic        rst;
  logic        lane_disable;
  logic        c_read;
  logic        c_write;
  logic [7:0]  c_address;
  logic [31:0] c_data_in;
  logic [31:0] c_data_out;
  logic [15:0] transport_layer_data_in;
  logic [15:0] transport_layer_data_out;
  logic [7:0]  lane_0_rx_i;
  logic [7:0]  lane_1_rx_i;
  logic        data_incoming;
  logic        sbrx;
  logic        sbtx;
  logic [7:0]  lane_0_tx_o;
  logic [7:0]  lane_1_tx_o;
  logic        enable_scr;

  usb4_logical_layer_lite #(.TS_SYM(TS), .TS_COUNT(TSC), .SB_DEB(DEB)) dut (
    .local_clk                (local_clk),
    .rst                      (rst),
    .lane_disable             (lane_disable),
    .c_read                   (c_read),
    .c_write                  (c_write),
    .c_address                (c_address),
    .c_data_in                (c_data_in),
    .c_data_out               (c_data_out),
    .transport_layer_data_in  (transport_layer_data_in),
    .transport_layer_data_out (transport_layer_data_out),
    .lane_0_rx_i              (lane_0_rx_i),
    .lane_1_rx_i              (lane_1_rx_i),
    .data_incoming            (data_incoming),
    .sbrx                     (sbrx),
    .sbtx                     (sbtx),
    .lane_0_tx_o              (lane_0_tx_o),
    .lane_1_tx_o              (lane_1_tx_o),
    .enable_scr               (enable_scr)
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  int total = 0;
  int bad   = 0;

  // Model: link phase 0=CLd 1=training 2=CL0, plus counters and visible outputs.
  int          m_state, m_deb, m_match;
  bit          m_scr;
  logic [15:0] m_dout;
  logic [7:0]  m_tx0, m_tx1;
  logic [31:0] m_cdo;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_state = 0; m_deb = 0; m_match = 0; m_scr = 0;
    m_dout = 16'h0; m_tx0 = 8'h0; m_tx1 = 8'h0; m_cdo = 32'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int word = int'(a) / 4;
    int sat  = (m_match > 255) ? 255 : m_match;
    if (word == 0) return 32'(sat * 256 + m_state);
    if (word == 1) return 32'(m_scr);
    if (word == 2) return IDV;
    return 32'h0;
  endfunction

  task automatic check_all();
    chk("sbtx",   32'(sbtx),        32'(m_state != 0));
    chk("scr",    32'(enable_scr),  32'(m_state == 2 && m_scr));
    chk("tx0",    32'(lane_0_tx_o), 32'(m_tx0));
    chk("tx1",    32'(lane_1_tx_o), 32'(m_tx1));
    chk("rxdata", 32'(transport_layer_data_out), 32'(m_dout));
    chk("cdata",  c_data_out,       m_cdo);
  endtask

  // One clock: advance the model from the inputs the DUT samples, then compare.
  task automatic tick();
    bit ctrl_wr, retrain, match;
    if (c_read) m_cdo = model_read(c_address);
    if (m_state == 1) begin m_tx0 = TS; m_tx1 = TS; end
    else if (m_state == 2) begin
      m_tx0 = transport_layer_data_in[7:0];
      m_tx1 = transport_layer_data_in[15:8];
    end else begin m_tx0 = 8'h0; m_tx1 = 8'h0; end
    if (m_state == 2 && data_incoming) m_dout = {lane_1_rx_i, lane_0_rx_i};
    ctrl_wr = c_write && (int'(c_address) / 4 == 1);
    retrain = ctrl_wr && c_data_in[1];
    match   = (lane_0_rx_i == TS) && (lane_1_rx_i == TS);
    if (m_state == 0) begin
      if (!lane_disable && sbrx) begin
        m_deb++;
        if (m_deb == DEB) begin m_state = 1; m_deb = 0; m_match = 0; end
      end else m_deb = 0;
    end else if (lane_disable || !sbrx) begin
      m_state = 0; m_deb = 0; m_match = 0;
    end else if (m_state == 1) begin
      if (data_incoming) begin
        if (match) begin
          m_match++;
          if (m_match == TSC) begin m_state = 2; m_match = 0; end
        end else m_match = 0;
      end
    end else if (retrain) begin
      m_state = 1; m_match = 0;
    end
    if (ctrl_wr) m_scr = c_data_in[0];
    @(posedge local_clk);
    #1;
    check_all();
  endtask

  task automatic rd(input logic [7:0] a);
    c_read = 1'b1; c_address = a;
    tick();
    c_read = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    c_write = 1'b1; c_address = a; c_data_in = d;
    tick();
    c_write = 1'b0;
  endtask

  task automatic ts_cycles(input int n);
    lane_0_rx_i = TS; lane_1_rx_i = TS;
    for (int i = 0; i < n; i++) begin
      data_incoming = 1'b1;
      tick();
      if (i % 3 == 0) begin
        data_incoming = 1'b0;
        tick();
      end
    end
    data_incoming = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sbtx"}, 32'(sbtx), 32'h0);
    chk({tag, "_tx0"},  32'(lane_0_tx_o), 32'h0);
    chk({tag, "_tx1"},  32'(lane_1_tx_o), 32'h0);
    chk({tag, "_rx"},   32'(transport_layer_data_out), 32'h0);
    chk({tag, "_cd"},   c_data_out, 32'h0);
    chk({tag, "_scr"},  32'(enable_scr), 32'h0);
  endtask

  initial begin
    rst = 1'b0; lane_disable = 1'b0; c_read = 1'b0; c_write = 1'b0;
    c_address = 8'h0; c_data_in = 32'h0; transport_layer_data_in = 16'h0;
    lane_0_rx_i = 8'h0; lane_1_rx_i = 8'h0; data_incoming = 1'b0; sbrx = 1'b0;
    model_clear();
    repeat (3) @(posedge local_clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // Bring-up: sideband debounce then training symbols on the lanes.
    sbrx = 1'b1;
    repeat (DEB - 1) tick();
    chk("deb_not_yet", 32'(sbtx), 32'h0);
    tick();
    chk("deb_done_sbtx", 32'(sbtx), 32'h1);
    tick();
    chk("ts_tx0", 32'(lane_0_tx_o), 32'(TS));
    chk("ts_tx1", 32'(lane_1_tx_o), 32'(TS));

    // Training counter: a mismatch restarts the run, idles hold it.
    ts_cycles(10);
    lane_0_rx_i = 8'h00; data_incoming = 1'b1;
    tick();
    ts_cycles(TSC - 1);
    rd(8'h00);
    chk("status_15", c_data_out, 32'h0000_0F01);
    data_incoming = 1'b1;
    tick();
    data_incoming = 1'b0;
    rd(8'h00);
    chk("status_cl0", c_data_out, 32'h0000_0002);

    // CL0 data path in both directions.
    transport_layer_data_in = 16'hA55A;
    tick();
    chk("stripe_l0", 32'(lane_0_tx_o), 32'h5A);
    chk("stripe_l1", 32'(lane_1_tx_o), 32'hA5);
    lane_0_rx_i = 8'h12; lane_1_rx_i = 8'h34; data_incoming = 1'b1;
    tick();
    data_incoming = 1'b0;
    chk("merge", 32'(transport_layer_data_out), 32'h3412);

    // Config: scrambler enable, retrain with same-cycle read, ID and unmapped.
    wr(8'h04, 32'h1);
    chk("scr_on", 32'(enable_scr), 32'h1);
    c_read = 1'b1;
    wr(8'h04, 32'h3);
    c_read = 1'b0;
    chk("rd_prewrite", c_data_out, 32'h1);
    rd(8'h00);
    chk("retrain_state", c_data_out, 32'h1);
    rd(8'h04);
    chk("ctrl_rd", c_data_out, 32'h1);
    chk("scr_in_train", 32'(enable_scr), 32'h0);
    rd(8'h0B);
    chk("id", c_data_out, IDV);
    wr(8'h20, 32'hFFFF_FFFF);
    rd(8'h20);
    chk("unmapped", c_data_out, 32'h0);

    // Back to CL0, then sideband teardown.
    ts_cycles(TSC);
    chk("scr_back", 32'(enable_scr), 32'h1);
    sbrx = 1'b0;
    tick();
    chk("down_sbtx", 32'(sbtx), 32'h0);
    tick();
    chk("down_tx0", 32'(lane_0_tx_o), 32'h0);

    // Asynchronous reset in the middle of CL0.
    sbrx = 1'b1;
    repeat (DEB) tick();
    ts_cycles(TSC);
    rd(8'h00);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_zero("async_rst");
    @(posedge local_clk);
    #1;
    rst = 1'b1;

    // Random traffic, biased so the link trains up regularly.
    for (int i = 0; i < 4000; i++) begin
      lane_disable  = ($urandom_range(0, 99) < 1);
      sbrx          = ($urandom_range(0, 99) < 98);
      data_incoming = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 96) begin
        lane_0_rx_i = TS; lane_1_rx_i = TS;
      end else begin
        lane_0_rx_i = 8'($urandom); lane_1_rx_i = 8'($urandom);
      end
      transport_layer_data_in = 16'($urandom);
      c_read  = ($urandom_range(0, 99) < 30);
      c_write = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 4))
        0: c_address = 8'h00;
        1: c_address = 8'h04;
        2: c_address = 8'h08;
        3: c_address = 8'h20;
        default: c_address = 8'($urandom);
      endcase
      c_address = {c_address[7:2], 2'($urandom)};
      c_data_in = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
